accum_seq: RTL

//  Sequential accumulator that feeds the 8-bit add/sub datapath (adder_8) one operand per cycle.
//  A start command with length N collects N operands over a valid/ready stream and folds each into
//  an 8-bit two's-complement accumulator (acc = acc +/- operand).

---
 rtl/accum_pkg.sv | 32 +++
 rtl/accum_seq_adder_8.sv | 19 +
 rtl/accum_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared types, constants and overflow/saturation helpers for the accum_seq accumulator.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_t;

  localparam logic       OP_ADD  = 1'b0;
  localparam logic       OP_SUB  = 1'b1;
  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;

  // Signed overflow of one step: operand signs vs. result sign, per operation.
  function automatic logic step_ovf(input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] sum, input logic op);
    logic same_sign;
    same_sign = (a[7] == b[7]);
    if (op == OP_ADD) begin
      return same_sign && (sum[7] != a[7]);
    end else begin
      return !same_sign && (sum[7] != a[7]);
    end
  endfunction

  // On overflow the true result keeps the sign of the accumulator operand.
  function automatic logic [7:0] sat_value(input logic [7:0] a);
    return a[7] ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/accum_seq_adder_8.sv
// adder_8: 8-bit modulo add/subtract datapath (op=0 add, op=1 subtract); carry-out is discarded.
module adder_8
  import accum_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       op,
  output logic [7:0] sum
);

  logic [7:0] b_eff_s;
  logic [8:0] full_s;

  // Subtraction as a + ~b + 1.
  assign b_eff_s = (op == OP_SUB) ? ~b : b;
  assign full_s  = {1'b0, a} + {1'b0, b_eff_s} + {8'h00, op};
  assign sum     = full_s[7:0];

endmodule

// File: rtl/accum_seq.sv
// accum_seq: folds N streamed operands into an 8-bit accumulator and returns the result with a sticky
// signed-overflow flag. Optional ACCUM_SAT_EN clamps the accumulator on overflow instead of wrapping.
module accum_seq
  import accum_pkg::*;
#(
  parameter int          CNT_W    = 4,
  parameter logic [7:0]  INIT_ACC = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_ovf,
  output logic             busy
);

  accum_state_t     state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       sum_s;
  logic             step_ovf_s;
  logic [7:0]       acc_step_s;

  adder_8 u_adder (
    .a   (acc_q),
    .b   (in_data),
    .op  (in_op),
    .sum (sum_s)
  );

  assign step_ovf_s = step_ovf(acc_q, in_data, sum_s, in_op);

`ifdef ACCUM_SAT_EN
  assign acc_step_s = step_ovf_s ? sat_value(acc_q) : sum_s;
`else
  assign acc_step_s = sum_s;
`endif

  // Next-state, accumulator, counter and sticky-overflow update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = INIT_ACC;
          ovf_d = 1'b0;
          if (len != {CNT_W{1'b0}}) begin
            cnt_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_step_s;
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          ovf_d = ovf_q | step_ovf_s;
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= INIT_ACC;
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result fields are forced to zero outside DONE so idle/reset outputs read as 0.
  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : 8'h00;
  assign out_ovf   = out_valid & ovf_q;

endmodule
